seg7_display_ctrl: RTL and testbench

- Parametrised Avalon-MM slave driving up to eight 7-segment digits. Next generation of the board's single-register seven-segment PIO.
- Adds on-chip hex decode, per-digit decimal point, blanking and blink masks, a programmable blink prescaler, and an atomic ADD register for counter-style software.
- Sits on the Nios II data master; segment outputs go straight to the DE0 HEX display pins.

---
 rtl/seg7_display_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_display_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Avalon-MM seven-segment controller: hex decode, dp/blank/blink masks, blink prescaler, atomic ADD.
// Latency: zero-wait-state combinational reads; seg_out follows any register or phase change by one clk.
// Backpressure: none, the slave accepts every access and never stalls the master.
module seg7_display_ctrl #(
    parameter int           NUM_DIGITS      = 4,
    parameter logic [31:0]  RESET_VALUE     = 32'd0,
    parameter logic [31:0]  BLINK_DIV_RESET = 32'd25000000,
    parameter int           DIV_WIDTH       = 26,
    parameter bit           ACTIVE_LOW      = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [8*NUM_DIGITS-1:0]   seg_out
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [VW-1:0]            value;
    logic [NUM_DIGITS-1:0]    dp_en;
    logic [NUM_DIGITS-1:0]    blank;
    logic [NUM_DIGITS-1:0]    blink;
    logic [DIV_WIDTH-1:0]     blink_div;
    logic [DIV_WIDTH-1:0]     cnt;
    logic                     phase;
    logic [8*NUM_DIGITS-1:0]  seg_nxt;
    logic [8*NUM_DIGITS-1:0]  seg_q;
    logic                     wr;
    logic                     unused_wd;

    assign wr        = chipselect & ~write_n;
    assign unused_wd = &{1'b0, writedata};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] polarize(input logic [7:0] p);
        return ACTIVE_LOW ? ~p : p;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= RESET_VALUE[VW-1:0];
            dp_en <= '0;
            blank <= '0;
            blink <= '0;
        end else if (wr) begin
            case (address)
                2'd0: value <= writedata[VW-1:0];
                2'd1: begin
                    dp_en <= writedata[NUM_DIGITS-1:0];
                    blank <= writedata[8 +: NUM_DIGITS];
                    blink <= writedata[16 +: NUM_DIGITS];
                end
                2'd3: value <= value + writedata[VW-1:0];
                default: ;
            endcase
        end
    end

    // A BLINK_DIV write restarts the blink period with the digits visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_div <= BLINK_DIV_RESET[DIV_WIDTH-1:0];
            cnt       <= BLINK_DIV_RESET[DIV_WIDTH-1:0];
            phase     <= 1'b1;
        end else if (wr && address == 2'd2) begin
            blink_div <= writedata[DIV_WIDTH-1:0];
            cnt       <= writedata[DIV_WIDTH-1:0];
            phase     <= 1'b1;
        end else if (blink_div == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end else begin
            cnt   <= blink_div;
            phase <= ~phase;
        end
    end

    always_comb begin
        seg_nxt = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (blank[d] || (blink[d] && !phase))
                seg_nxt[8*d +: 8] = polarize(8'h00);
            else
                seg_nxt[8*d +: 8] = polarize({dp_en[d], hex7(value[4*d +: 4])});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < NUM_DIGITS; d++)
                seg_q[8*d +: 8] <= polarize({1'b0, hex7(RESET_VALUE[4*d +: 4])});
        end else begin
            seg_q <= seg_nxt;
        end
    end

    assign seg_out = seg_q;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[VW-1:0] = value;
            2'd1: begin
                readdata[NUM_DIGITS-1:0]  = dp_en;
                readdata[8 +: NUM_DIGITS]  = blank;
                readdata[16 +: NUM_DIGITS] = blink;
            end
            2'd2: readdata[DIV_WIDTH-1:0] = blink_div;
            default: readdata[0] = phase;
        endcase
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl (defaults, 4 digits): vector table, blink/reset sequences, random traffic vs model.
module tb_seg7_display_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] seg_out;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_display_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers as plain values, blink phase from edges elapsed since the period restarted.
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_value;
    logic [3:0]  m_dp, m_blank, m_blink;
    int          m_div;
    int          m_k;
    logic [31:0] exp_seg;

    function automatic logic model_phase();
        if (m_div == 0) return 1'b1;
        return ((m_k / (m_div + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] model_seg();
        logic [31:0] s;
        logic [7:0]  p;
        s = '0;
        for (int d = 0; d < 4; d++) begin
            if (m_blank[d] || (m_blink[d] && !model_phase())) p = 8'h00;
            else p = {m_dp[d], hex_tab[m_value[4*d +: 4]]};
            s[8*d +: 8] = ~p;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {16'h0, m_value};
            2'd1: return {8'h0, 4'h0, m_blink, 4'h0, m_blank, 4'h0, m_dp};
            2'd2: return m_div;
            default: return {31'h0, model_phase()};
        endcase
    endfunction

    task automatic model_reset();
        m_value = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_blink = 4'h0;
        m_div = 25000000; m_k = 0;
        exp_seg = model_seg();
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] wd);
        exp_seg = model_seg();
        m_k++;
        if (we) begin
            case (a)
                2'd0: m_value = wd[15:0];
                2'd1: begin m_dp = wd[3:0]; m_blank = wd[11:8]; m_blink = wd[19:16]; end
                2'd2: begin m_div = int'(wd[25:0]); m_k = 0; end
                default: m_value = m_value + wd[15:0];
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, model follows the rising edge, ends on the next falling edge.
    task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        @(posedge clk);
        model_edge(cs && !wn, a, wd);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic read_chk(input string name, input logic [1:0] a);
        address = a;
        #1;
        check(name, readdata, model_read(a));
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [1:0]  ca;
        logic [31:0] rd;
        logic [31:0] seg;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_12AF, 2'd0, 32'h0000_12AF, 32'hF9A4888E};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_FFFE, 2'd0, 32'h0000_FFFE, 32'h8E8E8E86};
        vecs[2]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0003, 2'd0, 32'h0000_0001, 32'hC0C0C0F9};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0201, 2'd1, 32'h0000_0201, 32'hC0C0FF79};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_FFFF, 2'd0, 32'h0000_0001, 32'hC0C0FF79};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0201, 32'hC0C0FF79};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h000F_0F0F, 32'hFFFFFFFF};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, 32'hC0C0C0F9};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, 32'hC0C0C0C0};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'h0400_0000, 2'd2, 32'h0000_0000, 32'hC0C0C0C0};
        vecs[10] = '{1'b1, 1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h0000_0001, 32'hC0C0C0C0};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 32'd25000000,  2'd2, 32'd25000000,  32'hC0C0C0C0};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        check("reset_seg", seg_out, 32'hC0C0C0C0);
        address = 2'd0; #1; check("reset_value", readdata, 32'h0);
        address = 2'd1; #1; check("reset_ctrl", readdata, 32'h0);
        address = 2'd2; #1; check("reset_div", readdata, 32'd25000000);
        address = 2'd3; #1; check("reset_phase", readdata, 32'h1);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].cs, vecs[i].wn, vecs[i].a, vecs[i].wd);
            idle();
            address = vecs[i].ca;
            #1;
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].rd);
            check($sformatf("vec%0d_seg", i), seg_out, vecs[i].seg);
            check($sformatf("vec%0d_model", i), seg_out, exp_seg);
        end

        // Blink digit 0 with a 4-cycle half period, then disable blinking.
        step(1'b1, 1'b0, 2'd0, 32'h0000_0008);
        step(1'b1, 1'b0, 2'd1, 32'h0001_0000);
        step(1'b1, 1'b0, 2'd2, 32'd3);
        for (int i = 1; i <= 16; i++) begin
            idle();
            address = 2'd3;
            #1;
            check($sformatf("blink_phase%0d", i), readdata, {31'h0, ((i / 4) % 2) == 0});
            check($sformatf("blink_seg%0d", i), seg_out, exp_seg);
        end
        step(1'b1, 1'b0, 2'd2, 32'd0);
        for (int i = 0; i < 6; i++) begin
            idle();
            read_chk("steady_phase", 2'd3);
            check("steady_seg", seg_out, exp_seg);
        end
        check("steady_seg_const", seg_out, 32'hC0C0C080);

        // Reset pulse between edges mid-blink, then a write coincident with reset.
        step(1'b1, 1'b0, 2'd2, 32'd3);
        repeat (5) idle();
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        model_reset();
        #1;
        check("midblink_rst_seg", seg_out, 32'hC0C0C0C0);
        read_chk("midblink_rst_phase", 2'd3);
        read_chk("midblink_rst_ctrl", 2'd1);
        read_chk("midblink_rst_div", 2'd2);
        @(negedge clk);
        reset_n = 1'b0;
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b1;
        model_reset();
        read_chk("rst_write_dropped", 2'd0);
        step(1'b0, 1'b0, 2'd0, 32'h0000_5555);
        read_chk("cs0_write_ignored", 2'd0);
        check("cs0_seg", seg_out, exp_seg);

        // Random traffic, short blink periods so the phase moves often.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  a;
            logic [31:0] wd;
            a  = 2'($urandom_range(0, 3));
            wd = (a == 2'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a, wd);
            read_chk($sformatf("rand%0d_rd", i), 2'($urandom_range(0, 3)));
            check($sformatf("rand%0d_seg", i), seg_out, exp_seg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
